// File: rtl/top.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit frames,
// and shows the last accepted byte on two hex digits plus status LEDs.
module top #(
    parameter int TIMEOUT = 50000
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [9:0] LEDR,
    input  logic       ps2_clk,
    input  logic       ps2_dat
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          parity_bit, parity_nxt;
    logic [TW-1:0] timeout_cnt;
    logic [7:0]    display;
    logic          err_flag;
    logic          toggle;

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic          timed_out;
    logic          accept, reject;

    logic          unused_inputs;
    assign unused_inputs = ^{KEY[3:1], SW[9:1]};

    assign fall      = clk_prev & ~clk_s2;
    assign timed_out = (state != IDLE) && !fall && (timeout_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt  = state;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift;
        parity_nxt = parity_bit;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !dat_s2) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_nxt[bit_cnt] = dat_s2;
                    bit_nxt            = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_nxt = dat_s2;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_nxt = IDLE;
                    if (dat_s2 && ((^shift) ^ parity_bit))
                        accept = 1'b1;
                    else
                        reject = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A stalled frame is thrown away entirely so the next start bit begins clean
        if (timed_out) begin
            state_nxt = IDLE;
            bit_nxt   = 3'd0;
            shift_nxt = 8'd0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY[0]) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            clk_prev    <= 1'b1;
            dat_s1      <= 1'b1;
            dat_s2      <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 8'd0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            display     <= 8'd0;
            err_flag    <= 1'b0;
            toggle      <= 1'b0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            clk_prev   <= clk_s2;
            dat_s1     <= ps2_dat;
            dat_s2     <= dat_s1;
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            parity_bit <= parity_nxt;
            if (state == IDLE || fall || timed_out)
                timeout_cnt <= '0;
            else
                timeout_cnt <= timeout_cnt + 1'b1;
            if (accept && !SW[0])
                display <= shift;
            if (accept)
                toggle <= ~toggle;
            if (reject || timed_out)
                err_flag <= 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign HEX0 = seg7(display[3:0]);
    assign HEX1 = seg7(display[7:4]);
    assign LEDR = {toggle, err_flag, display};

endmodule

// File: tb/tb_top.sv
// Directed bench for the PS/2 receiver: drives whole and broken frames and
// checks LEDs and hex digits against hand-computed values.
module tb_top;

    localparam int HALF = 20;

    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY      = 4'hF;
    logic [9:0] SW       = 10'd0;
    logic [6:0] HEX0, HEX1;
    logic [9:0] LEDR;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;

    int checks   = 0;
    int failures = 0;

    top dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .LEDR     (LEDR),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, falling edge, then clock back high
    task automatic applyStimulus(input logic b);
        ps2_dat = b;
        waitCycles(HALF);
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, data, 1'b0};
        for (int i = 0; i < 11; i++)
            applyStimulus(bits[i]);
        ps2_dat = 1'b1;
        waitCycles(4);
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        KEY[0] = 1'b0;
        waitCycles(3);
    endtask

    initial begin
        doReset();
        checkOutput("reset_ledr", LEDR, 10'h000);
        checkOutput("reset_hex0", {3'b0, HEX0}, 10'h040);
        checkOutput("reset_hex1", {3'b0, HEX1}, 10'h040);
        KEY[0] = 1'b1;
        waitCycles(5);

        sendFrame(8'h1C, 1'b0, 1'b1);
        checkOutput("first_1c_ledr", LEDR, 10'h21C);
        checkOutput("first_1c_hex1", {3'b0, HEX1}, 10'h079);
        checkOutput("first_1c_hex0", {3'b0, HEX0}, 10'h046);

        sendFrame(8'hF0, 1'b1, 1'b1);
        checkOutput("b2b_f0_ledr", LEDR, 10'h0F0);
        checkOutput("b2b_f0_hex1", {3'b0, HEX1}, 10'h00E);
        checkOutput("b2b_f0_hex0", {3'b0, HEX0}, 10'h040);
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkOutput("b2b_1c_ledr", LEDR, 10'h21C);
        checkOutput("b2b_1c_hex0", {3'b0, HEX0}, 10'h046);

        sendFrame(8'h1C, 1'b1, 1'b1);
        checkOutput("bad_parity_ledr", LEDR, 10'h31C);

        doReset();
        KEY[0] = 1'b1;
        waitCycles(5);
        sendFrame(8'h55, 1'b1, 1'b0);
        checkOutput("bad_stop_ledr", LEDR, 10'h100);

        doReset();
        checkOutput("reset_clears_err", LEDR, 10'h000);
        KEY[0] = 1'b1;
        waitCycles(5);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        ps2_dat = 1'b1;
        waitCycles(60000);
        checkOutput("timeout_err", LEDR, 10'h100);
        sendFrame(8'h5A, 1'b1, 1'b1);
        checkOutput("after_timeout_ledr", LEDR, 10'h35A);
        checkOutput("after_timeout_hex1", {3'b0, HEX1}, 10'h012);
        checkOutput("after_timeout_hex0", {3'b0, HEX0}, 10'h008);

        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        ps2_dat = 1'b1;
        doReset();
        checkOutput("midframe_reset_ledr", LEDR, 10'h000);
        KEY[0] = 1'b1;
        waitCycles(5);
        sendFrame(8'h29, 1'b0, 1'b1);
        checkOutput("post_reset_29_byte", {2'b0, LEDR[7:0]}, 10'h029);
        checkOutput("post_reset_29_err", {9'b0, LEDR[8]}, 10'h000);
        checkOutput("post_reset_29_tog", {9'b0, LEDR[9]}, 10'h001);

        SW[0] = 1'b1;
        sendFrame(8'h1C, 1'b0, 1'b1);
        checkOutput("freeze_ledr", LEDR, 10'h029);
        checkOutput("freeze_hex0", {3'b0, HEX0}, 10'h010);
        checkOutput("freeze_hex1", {3'b0, HEX1}, 10'h024);
        SW[0] = 1'b0;

        sendFrame(8'hF0, 1'b1, 1'b1);
        checkOutput("unfreeze_f0_ledr", LEDR, 10'h2F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
